uart_rx_core: RTL

- Receive-side serial-to-parallel stage for the team's asynchronous serial link.
- Samples an already-synchronized serial line at mid-bit and assembles LSB-first frames: 1 start, DATA_BITS data, 1 stop.
- Presents each byte with ready, framing and overrun status to the downstream packet logic.
- Bit timing comes from an internal 1-based wrapping period counter that produces a mid-bit sample strobe.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_core_bit_period_timer.sv | 37 +++
 rtl/uart_rx_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and sizing helpers for the UART receive core.
//   rx_state_t  - receiver FSM state encoding
//   half_of()   - mid-bit sample point within a bit period
//   idx_width() - width of the data-bit index counter
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_CNT_BITS     = 8;

  function automatic int half_of(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  function automatic int idx_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/uart_rx_core_bit_period_timer.sv
// bit_period_timer: 1-based wrapping bit-period counter with mid-bit strobe.
//   clk, rst    - system clock, synchronous active-high reset
//   clear       - reload count to 1 on the next edge (has priority over enable)
//   enable      - advance count 1..CLKS_PER_BIT, wrapping back to 1
//   count       - current period position
//   mid_strobe  - high while count equals CLKS_PER_BIT/2
module bit_period_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  output logic [CNT_BITS-1:0] count,
  output logic                mid_strobe
);

  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0] HALF = CNT_BITS'(half_of(CLKS_PER_BIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= ONE;
    end else if (clear) begin
      count <= ONE;
    end else if (enable) begin
      count <= (count == LAST) ? ONE : count + ONE;
    end
  end

  assign mid_strobe = (count == HALF);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: mid-bit sampling UART receiver, LSB-first frames of
// 1 start bit, DATA_BITS data bits, 1 stop bit.
//   clk, rst       - system clock, synchronous active-high reset
//   serial_in      - already-synchronized serial line (idles high)
//   data_read      - consumer pulse; clears data_ready and overrun_error
//   rx_data        - payload of the last loaded frame
//   data_ready     - unread rx_data present
//   framing_error  - stop bit of the last loaded frame sampled low
//   overrun_error  - a frame was loaded over unread data
//   busy           - receiver is not IDLE
//   sample_strobe  - mid-bit sample point while a frame is in progress
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy,
  output logic                 sample_strobe
);

  localparam int IDX_W = idx_width(DATA_BITS);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  rx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 prev_line;
  logic [CNT_BITS-1:0]  period_count;
  logic                 mid_strobe;
  logic                 start_det;
  logic                 load;
  logic                 to_idle;
  logic                 timer_clear;
  logic                 timer_enable;

  assign start_det     = (state == IDLE) && prev_line && !serial_in;
  assign sample_strobe = mid_strobe && (state != IDLE);
  assign load          = sample_strobe && (state == STOP);

  // Every edge that lands in IDLE reloads the counter to 1, so a start edge
  // always begins from count 1 and advances on that same edge; this puts the
  // first mid-bit strobe HALF-1 edges after the start edge.
  assign to_idle      = ((state == IDLE) && !start_det) || load ||
                        (sample_strobe && (state == START) && serial_in);
  assign timer_clear  = to_idle && (period_count != CNT_ONE);
  assign timer_enable = (state != IDLE) || start_det;

  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_BITS    (CNT_BITS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .count     (period_count),
    .mid_strobe(mid_strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift         <= '0;
      bit_idx       <= '0;
      prev_line     <= 1'b1;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      prev_line <= serial_in;

      // A load in the same cycle takes precedence over the consumer's read.
      if (data_read && !load) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_det) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (sample_strobe) begin
            if (serial_in) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (sample_strobe) begin
            shift   <= {serial_in, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (sample_strobe) begin
            rx_data       <= shift;
            data_ready    <= 1'b1;
            framing_error <= !serial_in;
            if (data_ready && !data_read) begin
              overrun_error <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
